// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface if_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rvalid, input rdata);
  modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, a one-entry stall
// buffer, and the IF/ID pipeline register.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  if_fetch_stage_if.master         imem,
  input  logic                     i_stall,
  input  logic                     i_flush,
  input  logic [31:0]              i_branch_target,
  output logic [31:0]              o_pc_out,
  output logic [31:0]              o_instruction_out,
  output logic                     o_valid_out
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DISCARD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        handshake;
  logic        deliver;
  logic [31:0] deliver_pc, deliver_instr;

  assign handshake = (state_q == S_FETCH) && imem.ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      buf_pc_q     <= '0;
      buf_instr_q  <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    deliver       = 1'b0;
    deliver_pc    = pc_q;
    deliver_instr = imem.rdata;

    if (i_flush) begin
      pc_d = i_branch_target;
      // A request already accepted by memory must still have its response drained.
      unique case (state_q)
        S_FETCH:            state_d = handshake ? S_DISCARD : S_FETCH;
        S_WAIT, S_DISCARD:  state_d = imem.rvalid ? S_FETCH : S_DISCARD;
        S_HOLD:             state_d = S_FETCH;
      endcase
    end else begin
      unique case (state_q)
        S_FETCH: if (handshake) state_d = S_WAIT;
        S_WAIT: begin
          if (imem.rvalid) begin
            if (i_stall) begin
              buf_pc_d    = pc_q;
              buf_instr_d = imem.rdata;
              state_d     = S_HOLD;
            end else begin
              deliver = 1'b0 | 1'b1;
              state_d = S_FETCH;
            end
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            deliver       = 1'b1;
            deliver_pc    = buf_pc_q;
            deliver_instr = buf_instr_q;
            state_d       = S_FETCH;
          end
        end
        S_DISCARD: if (imem.rvalid) state_d = S_FETCH;
      endcase
      if (deliver) pc_d = pc_q + 32'd4;
    end

    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (i_flush) begin
      ifid_pc_d    = '0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (!i_stall) begin
      if (deliver) begin
        ifid_pc_d    = deliver_pc;
        ifid_instr_d = deliver_instr;
        ifid_valid_d = 1'b1;
      end else begin
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    imem.req          = (state_q == S_FETCH);
    imem.addr         = pc_q;
    o_pc_out          = ifid_pc_q;
    o_instruction_out = ifid_instr_q;
    o_valid_out       = ifid_valid_q;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage against a request/buffer-level reference model,
// plus a directed PC-wrap check on a second instance with RESET_PC at the top of memory.
module tb_if_fetch_stage;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] W_DATA = 32'h0050_0093;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [31:0] target;
  logic [31:0] pc_out, instr_out, w_pc_out, w_instr_out;
  logic        valid_out, w_valid_out;
  logic        w_rvalid;

  if_fetch_stage_if mem  ();
  if_fetch_stage_if wmem ();

  always #5 clk = ~clk;

  if_fetch_stage u_dut (
    .i_clk(clk), .i_reset(rst), .imem(mem.master), .i_stall(stall), .i_flush(flush),
    .i_branch_target(target), .o_pc_out(pc_out), .o_instruction_out(instr_out),
    .o_valid_out(valid_out)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_wrap (
    .i_clk(clk), .i_reset(rst), .imem(wmem.master), .i_stall(1'b0), .i_flush(1'b0),
    .i_branch_target(32'h0), .o_pc_out(w_pc_out), .o_instruction_out(w_instr_out),
    .o_valid_out(w_valid_out)
  );

  // Wrap instance memory: always ready, answers exactly one cycle after accept.
  assign wmem.ready  = 1'b1;
  assign wmem.rvalid = w_rvalid;
  assign wmem.rdata  = W_DATA;
  always @(posedge clk) w_rvalid <= wmem.req && wmem.ready && !rst;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // Reference model: pending request (possibly stale), buffered instructions, IF/ID.
  logic [31:0] m_pc, m_ifid_pc, m_ifid_instr;
  logic        m_ifid_valid, m_pending, m_stale;
  logic [63:0] m_buf[$];

  function automatic logic model_req();
    return !m_pending && (m_buf.size() == 0);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_pending = 0; m_stale = 0; m_buf.delete();
    m_ifid_pc = 0; m_ifid_instr = NOP; m_ifid_valid = 0;
  endtask

  task automatic model_step(input logic r, f, s, rdy, rv, input logic [31:0] rd, tgt);
    logic hs, got;
    logic [63:0] ent;
    if (r) begin
      model_reset();
      return;
    end
    hs  = model_req() && rdy;
    got = 0;
    ent = '0;
    if (f) begin
      m_pc = tgt;
      m_buf.delete();
      if (m_pending && rv) m_pending = 0;
      else if (m_pending) m_stale = 1;
      if (hs) begin m_pending = 1; m_stale = 1; end
      m_ifid_pc = 0; m_ifid_instr = NOP; m_ifid_valid = 0;
    end else begin
      if (m_pending && rv) begin
        m_pending = 0;
        if (!m_stale) begin
          if (s) m_buf.push_back({m_pc, rd});
          else begin got = 1; ent = {m_pc, rd}; end
        end
      end else if (m_buf.size() != 0 && !s) begin
        got = 1;
        ent = m_buf.pop_front();
      end
      if (hs) begin m_pending = 1; m_stale = 0; end
      if (got) m_pc = m_pc + 32'd4;
      if (!s) begin
        if (got) begin
          m_ifid_pc = ent[63:32]; m_ifid_instr = ent[31:0]; m_ifid_valid = 1;
        end else begin
          m_ifid_instr = NOP; m_ifid_valid = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    check_eq("req",   {31'b0, mem.req},   {31'b0, model_req()});
    check_eq("addr",  mem.addr,           m_pc);
    check_eq("pc",    pc_out,             m_ifid_pc);
    check_eq("instr", instr_out,          m_ifid_instr);
    check_eq("valid", {31'b0, valid_out}, {31'b0, m_ifid_valid});
  endtask

  int          mem_cnt;
  logic [31:0] mem_addr;

  initial begin
    logic hs_mem;
    logic [31:0] cur_addr;
    rst = 1; stall = 0; flush = 0; target = 0;
    mem.ready = 0; mem.rvalid = 0; mem.rdata = 0;
    mem_cnt = 0; mem_addr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'b0, valid_out}, 32'd0);
    check_eq("rst_instr", instr_out, NOP);
    check_eq("rst_pc",    pc_out,    32'd0);
    check_eq("rst_req",   {31'b0, mem.req}, 32'd1);
    check_eq("rst_addr",  mem.addr,  32'd0);
    check_eq("wrap_addr0", wmem.addr, 32'hFFFF_FFFC);

    rst = 0;
    @(posedge clk); #1;
    check_eq("wrap_req_wait", {31'b0, wmem.req}, 32'd0);
    check_eq("wrap_valid_lat1", {31'b0, w_valid_out}, 32'd0);
    @(posedge clk); #1;
    check_eq("wrap_valid", {31'b0, w_valid_out}, 32'd1);
    check_eq("wrap_pc",    w_pc_out,    32'hFFFF_FFFC);
    check_eq("wrap_instr", w_instr_out, W_DATA);
    check_eq("wrap_addr1", wmem.addr,   32'h0000_0000);
    check_eq("wrap_req1",  {31'b0, wmem.req}, 32'd1);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst    = ($urandom_range(0, 299) == 0);
      stall  = ($urandom_range(0, 99) < 30);
      flush  = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 3))
        0:       target = 32'hFFFF_FFF8 | ($urandom & 32'h7);
        1:       target = $urandom;
        default: target = $urandom & 32'h0000_0FFC;
      endcase
      mem.ready  = ($urandom_range(0, 99) < 60);
      mem.rvalid = (mem_cnt == 1);
      mem.rdata  = mem.rvalid ? mem_word(mem_addr) : $urandom;
      hs_mem   = mem.req && mem.ready;
      cur_addr = mem.addr;
      @(posedge clk);
      model_step(rst, flush, stall, mem.ready, mem.rvalid, mem.rdata, target);
      if (rst)         mem_cnt = 0;
      else if (hs_mem) begin mem_cnt = $urandom_range(1, 3); mem_addr = cur_addr; end
      else if (mem_cnt > 0) mem_cnt--;
      #1;
      check_all();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: instruction word driven on bubbles (addi x0,x0,0).
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_reset  input  1  reset; synchronous, active-high.
REQ-005 o_imem_req  output  1  instruction-memory request valid.
REQ-006 o_imem_addr  output  32  request byte address; equals current PC.
REQ-007 i_imem_ready  input  1  memory accepts request this cycle when o_imem_req=1.
REQ-008 i_imem_rvalid  input  1  read data valid; at most one outstanding request.
REQ-009 i_imem_rdata  input  32  instruction word, qualified by i_imem_rvalid.
REQ-010 i_stall  input  1  load-use stall from hazard unit; IF/ID outputs hold.
REQ-011 i_flush  input  1  taken branch/jump resolved in EX; redirect fetch.
REQ-012 i_branch_target  input  32  redirect PC, qualified by i_flush.
REQ-013 o_pc_out  output  32  IF/ID register: PC of held instruction (feeds ID/EX i_pc_in).
REQ-014 o_instruction_out  output  32  IF/ID register: instruction word.
REQ-015 o_valid_out  output  1  IF/ID register holds a real instruction.

Function
REQ-016 States: FETCH, WAIT, HOLD, DISCARD; o_imem_req=1 only in FETCH; o_imem_addr=pc at all times.
REQ-017 FETCH: handshake (req & i_imem_ready) -> WAIT; no handshake -> stay, pc unchanged.
REQ-018 WAIT, i_imem_rvalid & !i_stall: load IF/ID {pc, rdata, valid=1}, pc<=pc+4, -> FETCH.
REQ-019 WAIT, i_imem_rvalid & i_stall: capture {pc, rdata} in one-entry buffer, -> HOLD; IF/ID unchanged.
REQ-020 HOLD: when i_stall=0 load buffer into IF/ID with valid=1, pc<=pc+4, -> FETCH.
REQ-021 DISCARD: response for a flushed request; on i_imem_rvalid drop data, -> FETCH.
REQ-022 i_flush has priority over all other events in every state: pc<=i_branch_target, IF/ID<={pc 0, NOP_INSTR, valid 0}, buffer dropped.
REQ-023 Flush next state: FETCH->FETCH if no handshake, ->DISCARD if handshake same cycle; WAIT->FETCH if i_imem_rvalid same cycle (data dropped), else ->DISCARD; HOLD->FETCH; DISCARD->DISCARD unless i_imem_rvalid same cycle, then ->FETCH.
REQ-024 IF/ID with no flush, no stall, no instruction delivered this cycle: valid<=0, instruction<=NOP_INSTR, pc held.
REQ-025 i_stall=1 without flush: IF/ID outputs hold exactly; fetching continues up to buffer capacity.
REQ-026 PC arithmetic modulo 2^32; pc+4 from 32'hFFFF_FFFC wraps to 0; bits [1:0] passed unmodified.
REQ-027 Minimum fetch-to-IF/ID latency: handshake in cycle N, rvalid in N+1, o_valid_out=1 in N+2; at most one instruction per two cycles.

Reset
REQ-028 i_reset=1 on a clock edge: pc<=RESET_PC, state<=FETCH, buffer empty, o_pc_out<=0, o_instruction_out<=NOP_INSTR, o_valid_out<=0.
REQ-029 Reset overrides flush and stall; o_imem_req=1 first cycle after reset release; rvalid for pre-reset request is ignored only if memory is also reset (memory shares i_reset).

Verification
REQ-030 Reset, i_imem_ready=1, rvalid one cycle after accept, rdata=32'h00500093 -> o_imem_addr=0, o_valid_out=1, o_pc_out=0 two cycles after first handshake; next addr=4.
REQ-031 i_stall=1 when rvalid for pc=8 arrives, held 3 cycles -> state HOLD, IF/ID holds pc=4; after stall drops, o_pc_out=8 next cycle, no instruction lost or duplicated.
REQ-032 i_flush=1, target=32'h100, while in WAIT for pc=0xC, rvalid 2 cycles later -> stale data discarded, o_valid_out=0, next request addr=0x100.
REQ-033 i_flush and i_stall together in HOLD -> IF/ID becomes NOP/valid 0, buffer dropped, next request at target.
REQ-034 i_imem_ready=0 for 4 cycles -> o_imem_req stays 1, addr stable, o_valid_out=0 bubbles with NOP_INSTR.
REQ-035 RESET_PC=32'hFFFF_FFFC -> first fetch at 0xFFFFFFFC, second at 0x00000000.
